bank_write_router: RTL and testbench

//  Parametrised successor to the two-way write demux. Routes a valid/ready write stream

---
 rtl/bank_write_router_pkg.sv | 6 +
 rtl/bank_write_router_if.sv | 9 +
 rtl/bank_write_router_bank_slot_fsm.sv | 23 ++
 rtl/bank_write_router.sv | 82 ++++++++
 tb/tb_bank_write_router.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_write_router_pkg.sv
// writer_pkg: bank ownership states and index type shared by bank_write_router and its bank slots.
package writer_pkg;
  typedef enum logic [1:0] {BANK_FREE, BANK_FILLING, BANK_FULL} bank_state_e;
  localparam int MAX_BANKS = 256;
  typedef logic [$clog2(MAX_BANKS)-1:0] bank_idx_t;
endpackage

// File: rtl/bank_write_router_if.sv
// bank_write_router_if: valid/ready write stream from the pixel writer into the router.
interface bank_write_router_if #(parameter int DATA_WIDTH = 64);
  logic in_valid;
  logic in_ready;
  logic in_sof;
  logic [DATA_WIDTH-1:0] data_in;
  modport master (output in_valid, output in_sof, output data_in, input in_ready);
  modport slave (input in_valid, input in_sof, input data_in, output in_ready);
endinterface

// File: rtl/bank_write_router_bank_slot_fsm.sv
// bank_slot_fsm: FREE/FILLING/FULL ownership state of one line-buffer bank.
module bank_slot_fsm
  import writer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fill_start,
  input  logic        fill_last,
  input  logic        drain,
  output bank_state_e state
);
  bank_state_e nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BANK_FREE;
    else state <= nxt;
  end
  // fill_start never arrives while FULL because the router stalls the writer
  always_comb begin
    nxt = (fill_start && fill_last) ? BANK_FULL :
          (fill_start && state == BANK_FREE) ? BANK_FILLING :
          (drain && state == BANK_FULL) ? BANK_FREE : state;
  end
endmodule

// File: rtl/bank_write_router.sv
// bank_write_router: round-robin write demux into NUM_BANKS line-buffer banks with back-pressure.
// Define WRITER_OVERFLOW_CNT_EN to build the saturating stall-cycle counter on overflow_cnt.
module bank_write_router
  import writer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BANKS  = 2,
  parameter int BANK_WORDS = 256,
  localparam int IDX_W     = $clog2(NUM_BANKS)
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  bank_write_router_if.slave     wr,
  output logic [NUM_BANKS-1:0]   wr_en_out,
  output logic [ADDR_WIDTH-1:0]  addr_out,
  output logic [DATA_WIDTH-1:0]  data_out,
  input  logic [NUM_BANKS-1:0]   bank_release,
  output logic [NUM_BANKS-1:0]   bank_full,
  output logic                   done_valid,
  output logic [IDX_W-1:0]       done_idx,
  output logic [15:0]            overflow_cnt
);
  bank_state_e state [NUM_BANKS];
  logic [IDX_W-1:0] cur_bank;
  logic [IDX_W-1:0] nxt_bank;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic ready;
  logic accept;
  logic last;
  assign ready = state[cur_bank] != BANK_FULL;
  assign wr.in_ready = ready;
  assign accept = wr.in_valid & ready;
  assign eff_addr = wr.in_sof ? '0 : wr_addr;
  assign last = eff_addr == ADDR_WIDTH'(BANK_WORDS - 1);
  assign nxt_bank = (cur_bank == IDX_W'(NUM_BANKS - 1)) ? '0 : cur_bank + 1'b1;
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    bank_slot_fsm u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .fill_start (accept && cur_bank == IDX_W'(b)),
      .fill_last  (accept && last && cur_bank == IDX_W'(b)),
      .drain      (bank_release[b]),
      .state      (state[b])
    );
    assign bank_full[b] = state[b] == BANK_FULL;
  end
  // in_sof restarts the current bank: the word lands at 0 and the fill continues from 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_bank   <= '0;
      wr_addr    <= '0;
      wr_en_out  <= '0;
      addr_out   <= '0;
      data_out   <= '0;
      done_valid <= 1'b0;
      done_idx   <= '0;
    end else begin
      wr_en_out  <= accept ? NUM_BANKS'(1) << cur_bank : '0;
      done_valid <= accept & last;
      if (accept) begin
        addr_out <= eff_addr;
        data_out <= wr.data_in;
        wr_addr  <= last ? '0 : eff_addr + 1'b1;
        if (last) begin
          cur_bank <= nxt_bank;
          done_idx <= cur_bank;
        end
      end
    end
  end
`ifdef WRITER_OVERFLOW_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_cnt <= '0;
    else if (wr.in_valid && !ready && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 1'b1;
  end
`else
  assign overflow_cnt = '0;
`endif
endmodule

// File: tb/tb_bank_write_router.sv
// tb_bank_write_router: scoreboard bench for bank_write_router (2-bank/256-word and 3-bank/4-word builds).
`timescale 1ns/1ps
module tb_bank_write_router;
  import writer_pkg::*;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int BW = 256;
`ifdef WRITER_OVERFLOW_CNT_EN
  localparam logic [15:0] OVF_EXP = 16'd40;
`else
  localparam logic [15:0] OVF_EXP = 16'd0;
`endif
  typedef struct {int bank; int addr; logic [DW-1:0] data; logic done;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bank_write_router_if #(.DATA_WIDTH(DW)) wr ();
  bank_write_router_if #(.DATA_WIDTH(DW)) wr3 ();
  logic [1:0] wr_en_out, bank_release, bank_full;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_out;
  logic done_valid;
  logic [0:0] done_idx;
  logic [15:0] overflow_cnt;
  logic [2:0] wr_en3, rel3, full3;
  logic [AW-1:0] addr3;
  logic [DW-1:0] data3;
  logic done3;
  logic [1:0] idx3;
  logic [15:0] ovf3;
  bank_write_router #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(2), .BANK_WORDS(BW)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr.slave), .wr_en_out(wr_en_out), .addr_out(addr_out),
    .data_out(data_out), .bank_release(bank_release), .bank_full(bank_full),
    .done_valid(done_valid), .done_idx(done_idx), .overflow_cnt(overflow_cnt));
  bank_write_router #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(3), .BANK_WORDS(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .wr(wr3.slave), .wr_en_out(wr_en3), .addr_out(addr3),
    .data_out(data3), .bank_release(rel3), .bank_full(full3),
    .done_valid(done3), .done_idx(idx3), .overflow_cnt(ovf3));
  exp_t sb[$];
  exp_t got;
  int m_bank, m_addr;
  int n_pass = 0;
  int n_total = 0;
  bit mon_en = 1'b0;
  // every registered write (or stray done pulse) of the 2-bank DUT is matched against the scoreboard
  always @(negedge clk) begin
    if (mon_en && (sb.size() > 0 || wr_en_out != 2'b00 || done_valid)) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_write: wr_en_out=%b addr=%0d done=%b, required no write", wr_en_out, addr_out, done_valid);
      end else begin
        got = sb.pop_front();
        if (wr_en_out !== 2'(1 << got.bank) || addr_out !== AW'(got.addr) || data_out !== got.data ||
            done_valid !== got.done || (got.done && done_idx !== 1'(got.bank)))
          $display("FAIL write: wr_en=%b addr=%0d data=%h done=%b idx=%0d, required wr_en=%b addr=%0d data=%h done=%b idx=%0d",
                   wr_en_out, addr_out, data_out, done_valid, done_idx, 2'(1 << got.bank), got.addr, got.data, got.done, got.bank);
        else n_pass++;
      end
    end
  end
  task automatic do_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    wr.in_valid = 1'b0; wr.in_sof = 1'b0; wr.data_in = '0;
    wr3.in_valid = 1'b0; wr3.in_sof = 1'b0; wr3.data_in = '0;
    bank_release = '0; rel3 = '0;
    sb.delete();
    m_bank = 0; m_addr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask
  task automatic send(input logic [DW-1:0] d, input logic sof, output bit acc);
    exp_t e;
    @(negedge clk);
    wr.in_valid = 1'b1; wr.data_in = d; wr.in_sof = sof;
    #1;
    acc = wr.in_ready;
    if (acc) begin
      e.bank = m_bank;
      e.addr = sof ? 0 : m_addr;
      e.data = d;
      e.done = e.addr == BW - 1;
      m_addr = e.done ? 0 : e.addr + 1;
      if (e.done) m_bank = (m_bank + 1) % 2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    wr.in_valid = 1'b0; wr.in_sof = 1'b0;
  endtask
  task automatic fill(input int n, input logic [DW-1:0] base, output int rej);
    bit acc;
    rej = 0;
    for (int i = 0; i < n; i++) begin
      send(base + DW'(i), 1'b0, acc);
      if (!acc) rej++;
    end
  endtask
  task automatic pulse_release(input logic [1:0] r);
    @(negedge clk);
    bank_release = r;
    @(posedge clk);
    #1;
    bank_release = '0;
  endtask
  task automatic test_reset();
    wr.in_valid = 1'b0; wr.in_sof = 1'b0; wr.data_in = '0;
    wr3.in_valid = 1'b0; wr3.in_sof = 1'b0; wr3.data_in = '0;
    bank_release = '0; rel3 = '0;
    repeat (2) @(negedge clk);
    n_total++;
    if (wr_en_out !== 2'b00 || addr_out !== '0 || data_out !== '0 || done_valid !== 1'b0 ||
        done_idx !== 1'b0 || overflow_cnt !== 16'd0 || bank_full !== 2'b00)
      $display("FAIL reset_outputs: wr_en=%b addr=%0d data=%h done=%b idx=%0d ovf=%0d full=%b, required all 0",
               wr_en_out, addr_out, data_out, done_valid, done_idx, overflow_cnt, bank_full);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (wr.in_ready !== 1'b1 || wr3.in_ready !== 1'b1)
      $display("FAIL reset_ready: in_ready=%b/%b, required 1/1", wr.in_ready, wr3.in_ready);
    else n_pass++;
  endtask
  task automatic test_stream();
    int rej;
    bit acc;
    do_reset();
    fill(BW, 64'hA000, rej);
    n_total++;
    if (rej !== 0) $display("FAIL stream_ready: rejected=%0d, required 0", rej);
    else n_pass++;
    n_total++;
    if (bank_full !== 2'b01) $display("FAIL stream_bank0_full: bank_full=%b, required 01", bank_full);
    else n_pass++;
    send(64'hB000, 1'b0, acc);
    n_total++;
    if (!acc || bank_full !== 2'b01) $display("FAIL stream_next_bank: acc=%b bank_full=%b, required 1 01", acc, bank_full);
    else n_pass++;
  endtask
  task automatic test_backpressure();
    int rej;
    int acc_cnt;
    bit acc;
    fill(BW - 1, 64'hB001, rej);
    n_total++;
    if (rej !== 0 || bank_full !== 2'b11) $display("FAIL bp_both_full: rejected=%0d bank_full=%b, required 0 11", rej, bank_full);
    else n_pass++;
    acc_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      send(64'hDEAD, 1'b0, acc);
      if (acc) acc_cnt++;
    end
    n_total++;
    if (acc_cnt !== 0) $display("FAIL bp_stall: accepted=%0d, required 0", acc_cnt);
    else n_pass++;
    @(negedge clk);
    bank_release = 2'b01;
    #1;
    n_total++;
    if (wr.in_ready !== 1'b0) $display("FAIL bp_no_bypass: in_ready=%b, required 0", wr.in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    bank_release = '0;
    n_total++;
    if (wr.in_ready !== 1'b1 || bank_full !== 2'b10) $display("FAIL bp_release: in_ready=%b bank_full=%b, required 1 10", wr.in_ready, bank_full);
    else n_pass++;
    send(64'hC000, 1'b0, acc);
    n_total++;
    if (!acc) $display("FAIL bp_resume: accepted=%b, required 1", acc);
    else n_pass++;
  endtask
  task automatic test_sof();
    int rej;
    bit acc;
    do_reset();
    fill(100, 64'h5000, rej);
    send(64'h50FF, 1'b1, acc);
    n_total++;
    if (!acc || bank_full !== 2'b00) $display("FAIL sof_accept: acc=%b bank_full=%b, required 1 00", acc, bank_full);
    else n_pass++;
    fill(BW - 1, 64'h6000, rej);
    n_total++;
    if (rej !== 0 || bank_full !== 2'b01) $display("FAIL sof_refill: rejected=%0d bank_full=%b, required 0 01", rej, bank_full);
    else n_pass++;
  endtask
  task automatic test_release_ignored();
    int rej;
    bit acc;
    do_reset();
    fill(5, 64'h7000, rej);
    pulse_release(2'b11);
    n_total++;
    if (bank_full !== 2'b00 || wr.in_ready !== 1'b1) $display("FAIL rel_ignored_filling: bank_full=%b in_ready=%b, required 00 1", bank_full, wr.in_ready);
    else n_pass++;
    fill(BW - 5, 64'h7005, rej);
    pulse_release(2'b10);
    n_total++;
    if (rej !== 0 || bank_full !== 2'b01) $display("FAIL rel_ignored_free: rejected=%0d bank_full=%b, required 0 01", rej, bank_full);
    else n_pass++;
  endtask
  task automatic test_wrap3();
    int bad;
    do_reset();
    bad = 0;
    for (int w = 0; w < 12; w++) begin
      @(negedge clk);
      wr3.in_valid = 1'b1; wr3.data_in = DW'(w);
      #1;
      if (wr3.in_ready !== 1'b1) bad++;
      @(posedge clk);
      #1;
      wr3.in_valid = 1'b0;
      if (wr_en3 !== 3'(1 << (w / 4)) || addr3 !== AW'(w % 4) || data3 !== DW'(w) || done3 !== (w % 4 == 3) ||
          (w % 4 == 3 && idx3 !== 2'(w / 4))) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL wrap3_order: errors=%0d, required 0", bad);
    else n_pass++;
    n_total++;
    if (full3 !== 3'b111 || wr3.in_ready !== 1'b0) $display("FAIL wrap3_full: full=%b in_ready=%b, required 111 0", full3, wr3.in_ready);
    else n_pass++;
    @(negedge clk);
    rel3 = 3'b001;
    @(posedge clk);
    #1;
    rel3 = '0;
    @(negedge clk);
    wr3.in_valid = 1'b1; wr3.data_in = 64'h99;
    @(posedge clk);
    #1;
    wr3.in_valid = 1'b0;
    n_total++;
    if (wr_en3 !== 3'b001 || addr3 !== '0 || data3 !== 64'h99) $display("FAIL wrap3_back_to_0: wr_en=%b addr=%0d, required 001 0", wr_en3, addr3);
    else n_pass++;
  endtask
  task automatic test_overflow_and_async_reset();
    int rej;
    do_reset();
    fill(2 * BW, 64'h8000, rej);
    @(negedge clk);
    wr.in_valid = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    wr.in_valid = 1'b0;
    n_total++;
    if (overflow_cnt !== OVF_EXP) $display("FAIL overflow_cnt: got=%0d, required %0d", overflow_cnt, OVF_EXP);
    else n_pass++;
    pulse_release(2'b01);
    fill(10, 64'h9000, rej);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (wr_en_out !== 2'b00 || addr_out !== '0 || data_out !== '0 || done_valid !== 1'b0 || done_idx !== 1'b0 ||
        overflow_cnt !== 16'd0 || bank_full !== 2'b00 || wr.in_ready !== 1'b1)
      $display("FAIL async_reset: wr_en=%b addr=%0d data=%h done=%b ovf=%0d full=%b ready=%b, required all 0 ready 1",
               wr_en_out, addr_out, data_out, done_valid, overflow_cnt, bank_full, wr.in_ready);
    else n_pass++;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_sof();
    test_release_ignored();
    test_wrap3();
    test_overflow_and_async_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
